cpu_ctrl_fsm: RTL and testbench

Parametrised multi-cycle control state machine for the 16-bit RISC core. It sequences instruction fetch, PC update, decode, and execution of MOV (imm/shift), ADD, CMP, AND, MVN, LDR, STR and HALT. It drives every load/select strobe of the datapath, program counter, instruction register and RAM port. Memory access length is set by a parameter or by a ready handshake, so the same controller serves on-chip RAM and slower memories.

---
 rtl/cpu_ctrl_fsm.sv | 234 +++++++++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle control sequencer for the 16-bit RISC core.
// Walks fetch / PC update / decode, then the micro-step chain of each
// instruction, and decodes every datapath, PC, IR and RAM strobe from the
// current state. Memory states end either after a fixed cycle count or on a
// ready handshake, selected at elaboration time.
module cpu_ctrl_fsm #(
    parameter int MEM_WAIT      = 1,
    parameter bit MEM_HANDSHAKE = 1'b0,
    parameter int STATE_W       = 5
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [2:0]         opcode_i,
    input  logic [1:0]         op_i,
    input  logic               mem_ready_i,
    output logic [1:0]         nsel_o,
    output logic [1:0]         vsel_o,
    output logic               loada_o,
    output logic               loadb_o,
    output logic               loadc_o,
    output logic               loads_o,
    output logic               write_o,
    output logic               asel_o,
    output logic               bsel_o,
    output logic               loadpc_o,
    output logic               resetpc_o,
    output logic               loadir_o,
    output logic               loadaddr_o,
    output logic               msel_o,
    output logic               mwrite_o,
    output logic               mem_req_o,
    output logic               halted_o,
    output logic               illegal_o,
    output logic [STATE_W-1:0] state_o
);

    typedef enum logic [4:0] {
        S_RESET, S_FETCH, S_LOAD_IR, S_UPDATE_PC, S_DECODE,
        S_WRITE_IMM, S_GET_B, S_GET_A, S_ALU_SH, S_ALU_C,
        S_WRITE_RD, S_ALU_S, S_ADDR_C, S_LOAD_ADDR, S_MEM_RD,
        S_WRITE_MEM, S_GET_RD, S_PASS_C, S_MEM_WR, S_HALT
    } state_t;

    // Instruction class remembered from DECODE so later shared steps can route
    typedef enum logic [2:0] {
        C_SHIFT, C_ARITH, C_CMP, C_LDR, C_STR
    } instr_t;

    localparam logic [3:0] WaitLoad = 4'(MEM_WAIT - 1);

    state_t     state_q, state_d;
    instr_t     instr_q, instr_d;
    logic [3:0] waitCnt_q, waitCnt_d;
    logic       illegal_q, illegal_d;
    logic       memState;
    logic       memDone;

    assign memState = state_q inside {S_FETCH, S_MEM_RD, S_MEM_WR};
    assign memDone  = MEM_HANDSHAKE ? mem_ready_i : (waitCnt_q == 4'd0);

    // State, class, wait counter and illegal flag; reset wins over everything
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= S_RESET;
            instr_q   <= C_SHIFT;
            waitCnt_q <= 4'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            waitCnt_q <= waitCnt_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state sequencing; opcode/op only matter while in DECODE
    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        illegal_d = illegal_q;
        case (state_q)
            S_RESET:     state_d = S_FETCH;
            S_FETCH:     if (memDone) state_d = S_LOAD_IR;
            S_LOAD_IR:   state_d = S_UPDATE_PC;
            S_UPDATE_PC: state_d = S_DECODE;
            S_DECODE: begin
                casez ({opcode_i, op_i})
                    5'b110_10: state_d = S_WRITE_IMM;
                    5'b110_00, 5'b101_11: begin
                        instr_d = C_SHIFT;
                        state_d = S_GET_B;
                    end
                    5'b101_00, 5'b101_10: begin
                        instr_d = C_ARITH;
                        state_d = S_GET_B;
                    end
                    5'b101_01: begin
                        instr_d = C_CMP;
                        state_d = S_GET_B;
                    end
                    5'b011_00: begin
                        instr_d = C_LDR;
                        state_d = S_GET_A;
                    end
                    5'b100_00: begin
                        instr_d = C_STR;
                        state_d = S_GET_A;
                    end
                    5'b111_??: state_d = S_HALT;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
                    end
                endcase
            end
            S_WRITE_IMM: state_d = S_FETCH;
            S_GET_B:     state_d = (instr_q == C_SHIFT) ? S_ALU_SH : S_GET_A;
            S_GET_A: begin
                case (instr_q)
                    C_CMP:        state_d = S_ALU_S;
                    C_LDR, C_STR: state_d = S_ADDR_C;
                    default:      state_d = S_ALU_C;
                endcase
            end
            S_ALU_SH:    state_d = S_WRITE_RD;
            S_ALU_C:     state_d = S_WRITE_RD;
            S_WRITE_RD:  state_d = S_FETCH;
            S_ALU_S:     state_d = S_FETCH;
            S_ADDR_C:    state_d = S_LOAD_ADDR;
            S_LOAD_ADDR: state_d = (instr_q == C_STR) ? S_GET_RD : S_MEM_RD;
            S_MEM_RD:    if (memDone) state_d = S_WRITE_MEM;
            S_WRITE_MEM: state_d = S_FETCH;
            S_GET_RD:    state_d = S_PASS_C;
            S_PASS_C:    state_d = S_MEM_WR;
            S_MEM_WR:    if (memDone) state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_RESET;
        endcase
    end

    // Wait counter counts down inside a memory state and reloads on entry
    always_comb begin
        waitCnt_d = waitCnt_q;
        if (memState && (waitCnt_q != 4'd0)) begin
            waitCnt_d = waitCnt_q - 4'd1;
        end
        if ((state_d != state_q) && (state_d inside {S_FETCH, S_MEM_RD, S_MEM_WR})) begin
            waitCnt_d = WaitLoad;
        end
    end

    // Moore output decode: every strobe comes from the current state alone
    always_comb begin
        nsel_o     = 2'b00;
        vsel_o     = 2'b00;
        loada_o    = 1'b0;
        loadb_o    = 1'b0;
        loadc_o    = 1'b0;
        loads_o    = 1'b0;
        write_o    = 1'b0;
        asel_o     = 1'b0;
        bsel_o     = 1'b0;
        loadpc_o   = 1'b0;
        resetpc_o  = 1'b0;
        loadir_o   = 1'b0;
        loadaddr_o = 1'b0;
        msel_o     = 1'b0;
        mwrite_o   = 1'b0;
        mem_req_o  = 1'b0;
        halted_o   = 1'b0;
        case (state_q)
            S_RESET: begin
                loadpc_o  = 1'b1;
                resetpc_o = 1'b1;
            end
            S_FETCH:     mem_req_o = 1'b1;
            S_LOAD_IR:   loadir_o  = 1'b1;
            S_UPDATE_PC: loadpc_o  = 1'b1;
            S_WRITE_IMM: begin
                vsel_o  = 2'b01;
                write_o = 1'b1;
            end
            S_GET_B: begin
                nsel_o  = 2'b10;
                loadb_o = 1'b1;
            end
            S_GET_A:     loada_o = 1'b1;
            S_ALU_SH: begin
                asel_o  = 1'b1;
                loadc_o = 1'b1;
            end
            S_ALU_C:     loadc_o = 1'b1;
            S_WRITE_RD: begin
                nsel_o  = 2'b01;
                vsel_o  = 2'b11;
                write_o = 1'b1;
            end
            S_ALU_S:     loads_o = 1'b1;
            S_ADDR_C: begin
                bsel_o  = 1'b1;
                loadc_o = 1'b1;
            end
            S_LOAD_ADDR: loadaddr_o = 1'b1;
            S_MEM_RD: begin
                msel_o    = 1'b1;
                mem_req_o = 1'b1;
            end
            S_WRITE_MEM: begin
                nsel_o  = 2'b01;
                msel_o  = 1'b1;
                write_o = 1'b1;
            end
            S_GET_RD: begin
                nsel_o  = 2'b01;
                loadb_o = 1'b1;
            end
            S_PASS_C: begin
                asel_o  = 1'b1;
                loadc_o = 1'b1;
            end
            S_MEM_WR: begin
                msel_o    = 1'b1;
                mwrite_o  = 1'b1;
                mem_req_o = 1'b1;
            end
            S_HALT:      halted_o = 1'b1;
            default: ;
        endcase
    end

    assign illegal_o = illegal_q;
    assign state_o   = STATE_W'(state_q);

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: drives three controller instances (fixed wait 1, fixed
// wait 3, ready handshake) with random instruction streams. The stimulus side
// walks each instruction's micro-step list, pushes the expected strobe vector
// for every cycle into a per-instance queue, and a negedge monitor pops and
// compares against the live outputs.
module tb_cpu_ctrl_fsm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {
        T_RESET, T_FETCH, T_LOAD_IR, T_UPDATE_PC, T_DECODE,
        T_WRITE_IMM, T_GET_B, T_GET_A, T_ALU_SH, T_ALU_C,
        T_WRITE_RD, T_ALU_S, T_ADDR_C, T_LOAD_ADDR, T_MEM_RD,
        T_WRITE_MEM, T_GET_RD, T_PASS_C, T_MEM_WR, T_HALT, T_NONE
    } Step;

    typedef struct packed {
        logic [1:0] nsel;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       write;
        logic       asel;
        logic       bsel;
        logic       loadpc;
        logic       resetpc;
        logic       loadir;
        logic       loadaddr;
        logic       msel;
        logic       mwrite;
        logic       memReq;
        logic       halted;
        logic       illegal;
    } OutVec;

    logic       resetN   [3];
    logic [2:0] opcode   [3];
    logic [1:0] op       [3];
    logic       memReady [3];
    wire  [59:0] obsFlat;

    OutVec expQ [3][$];
    int checkCount = 0;
    int errorCount = 0;

    for (genvar g = 0; g < 3; g++) begin : gDut
        logic [1:0] nsel, vsel;
        logic loada, loadb, loadc, loads, write, asel, bsel, loadpc, resetpc;
        logic loadir, loadaddr, msel, mwrite, memReq, halted, illegal;
        logic [4:0] stateDbg;

        cpu_ctrl_fsm #(
            .MEM_WAIT      ((g == 1) ? 3 : 1),
            .MEM_HANDSHAKE (g == 2),
            .STATE_W       (5)
        ) dut (
            .clk_i       (clk),
            .reset_i     (resetN[g]),
            .opcode_i    (opcode[g]),
            .op_i        (op[g]),
            .mem_ready_i (memReady[g]),
            .nsel_o      (nsel),
            .vsel_o      (vsel),
            .loada_o     (loada),
            .loadb_o     (loadb),
            .loadc_o     (loadc),
            .loads_o     (loads),
            .write_o     (write),
            .asel_o      (asel),
            .bsel_o      (bsel),
            .loadpc_o    (loadpc),
            .resetpc_o   (resetpc),
            .loadir_o    (loadir),
            .loadaddr_o  (loadaddr),
            .msel_o      (msel),
            .mwrite_o    (mwrite),
            .mem_req_o   (memReq),
            .halted_o    (halted),
            .illegal_o   (illegal),
            .state_o     (stateDbg)
        );

        assign obsFlat[g*20 +: 20] = {nsel, vsel, loada, loadb, loadc, loads, write,
                                      asel, bsel, loadpc, resetpc, loadir, loadaddr,
                                      msel, mwrite, memReq, halted, illegal};
    end

    // Strobe vector each micro-step must show, taken from the step table
    function automatic OutVec expectVec(input Step s, input bit ill);
        OutVec v;
        v = '0;
        case (s)
            T_RESET:     begin v.loadpc = 1; v.resetpc = 1; end
            T_FETCH:     begin v.msel = 0; v.memReq = 1; end
            T_LOAD_IR:   v.loadir = 1;
            T_UPDATE_PC: v.loadpc = 1;
            T_WRITE_IMM: begin v.nsel = 2'b00; v.vsel = 2'b01; v.write = 1; end
            T_GET_B:     begin v.nsel = 2'b10; v.loadb = 1; end
            T_GET_A:     begin v.nsel = 2'b00; v.loada = 1; end
            T_ALU_SH:    begin v.asel = 1; v.loadc = 1; end
            T_ALU_C:     v.loadc = 1;
            T_WRITE_RD:  begin v.nsel = 2'b01; v.vsel = 2'b11; v.write = 1; end
            T_ALU_S:     v.loads = 1;
            T_ADDR_C:    begin v.bsel = 1; v.loadc = 1; end
            T_LOAD_ADDR: v.loadaddr = 1;
            T_MEM_RD:    begin v.msel = 1; v.memReq = 1; end
            T_WRITE_MEM: begin v.nsel = 2'b01; v.vsel = 2'b00; v.msel = 1; v.write = 1; end
            T_GET_RD:    begin v.nsel = 2'b01; v.loadb = 1; end
            T_PASS_C:    begin v.asel = 1; v.loadc = 1; end
            T_MEM_WR:    begin v.msel = 1; v.mwrite = 1; v.memReq = 1; end
            T_HALT:      begin v.halted = 1; v.illegal = ill; end
            default: ;
        endcase
        return v;
    endfunction

    // One cycle: set inputs, queue the expected outputs, advance past the edge
    task automatic applyStimulus(input int k, input Step s, input bit ill, input bit rdy,
                                 input bit rst, input logic [2:0] opc, input logic [1:0] opv,
                                 input bit doCheck);
        resetN[k]   = rst;
        memReady[k] = rdy;
        if (s == T_DECODE) begin
            opcode[k] = opc;
            op[k]     = opv;
        end else begin
            opcode[k] = 3'($urandom);
            op[k]     = 2'($urandom);
        end
        if (doCheck) expQ[k].push_back(expectVec(s, ill));
        @(posedge clk);
        #1;
    endtask

    // Hold reset low for two edges, starting from whatever step is showing
    task automatic doReset(input int k, input Step cur, input bit curIll, input bit chkCur);
        applyStimulus(k, cur, curIll, 1'($urandom), 1'b0, 3'd0, 2'd0, chkCur);
        applyStimulus(k, T_RESET, 1'b0, 1'($urandom), 1'b0, 3'd0, 2'd0, 1'b1);
        applyStimulus(k, T_RESET, 1'b0, 1'($urandom), 1'b1, 3'd0, 2'd0, 1'b1);
    endtask

    // A memory step lasts the fixed wait, or until the chosen ready cycle
    task automatic memStep(input int k, input Step s, input logic [2:0] opc, input logic [1:0] opv,
                           input Step abortAt, input int forceDur, output bit aborted);
        int dur;
        aborted = 1'b0;
        if (k == 2) dur = (forceDur > 0) ? forceDur : 1 + int'($urandom_range(0, 4));
        else        dur = (k == 1) ? 3 : 1;
        if (s == abortAt && dur < 3) dur = 3;
        for (int i = 0; i < dur; i++) begin
            if (s == abortAt && i == 1) begin
                applyStimulus(k, s, 1'b0, 1'b0, 1'b0, opc, opv, 1'b1);
                applyStimulus(k, T_RESET, 1'b0, 1'($urandom), 1'b1, opc, opv, 1'b1);
                aborted = 1'b1;
                return;
            end
            applyStimulus(k, s, 1'b0, (k == 2) ? (i == dur - 1) : 1'($urandom),
                          1'b1, opc, opv, 1'b1);
        end
    endtask

    // Full instruction: fetch overhead, then the micro-step list for {opcode, op}
    task automatic runInstr(input int k, input logic [2:0] opc, input logic [1:0] opv,
                            input int holdHalt, input Step abortAt, input int fetchDur,
                            output bit ill);
        Step body[$];
        bit  halts;
        bit  ab;
        ill   = 1'b0;
        halts = 1'b0;
        casez ({opc, opv})
            5'b11010:          body = '{T_WRITE_IMM};
            5'b11000, 5'b10111: body = '{T_GET_B, T_ALU_SH, T_WRITE_RD};
            5'b10100, 5'b10110: body = '{T_GET_B, T_GET_A, T_ALU_C, T_WRITE_RD};
            5'b10101:          body = '{T_GET_B, T_GET_A, T_ALU_S};
            5'b01100:          body = '{T_GET_A, T_ADDR_C, T_LOAD_ADDR, T_MEM_RD, T_WRITE_MEM};
            5'b10000:          body = '{T_GET_A, T_ADDR_C, T_LOAD_ADDR, T_GET_RD, T_PASS_C, T_MEM_WR};
            5'b111??:          halts = 1'b1;
            default: begin
                halts = 1'b1;
                ill   = 1'b1;
            end
        endcase
        memStep(k, T_FETCH, opc, opv, abortAt, fetchDur, ab);
        if (ab) return;
        applyStimulus(k, T_LOAD_IR, 1'b0, 1'($urandom), 1'b1, opc, opv, 1'b1);
        applyStimulus(k, T_UPDATE_PC, 1'b0, 1'($urandom), 1'b1, opc, opv, 1'b1);
        applyStimulus(k, T_DECODE, 1'b0, 1'($urandom), 1'b1, opc, opv, 1'b1);
        if (halts) begin
            for (int i = 0; i < holdHalt; i++)
                applyStimulus(k, T_HALT, ill, 1'($urandom), 1'b1, opc, opv, 1'b1);
            return;
        end
        foreach (body[i]) begin
            if (body[i] inside {T_MEM_RD, T_MEM_WR}) begin
                memStep(k, body[i], opc, opv, abortAt, 0, ab);
                if (ab) return;
            end else begin
                applyStimulus(k, body[i], 1'b0, 1'($urandom), 1'b1, opc, opv, 1'b1);
            end
        end
    endtask

    task automatic randomLegal(input int k, input int count);
        logic [4:0] legal [8] = '{5'b11010, 5'b11000, 5'b10111, 5'b10100,
                                  5'b10110, 5'b10101, 5'b01100, 5'b10000};
        logic [4:0] enc;
        bit ill;
        for (int n = 0; n < count; n++) begin
            enc = legal[$urandom_range(0, 7)];
            runInstr(k, enc[4:2], enc[1:0], 0, T_NONE, 0, ill);
        end
    endtask

    // Compare one cycle of a given instance against the queued expectation
    task automatic checkOutput(input int k, input OutVec got, input OutVec exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL dut%0d strobes t=%0t got=%05h expected=%05h", k, $time, got, exp);
        end
    endtask

    // Monitor: every falling edge, pop whatever each instance is expected to show
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (expQ[k].size() > 0) begin
                OutVec e;
                OutVec o;
                e = expQ[k].pop_front();
                o = OutVec'(obsFlat[k*20 +: 20]);
                checkOutput(k, o, e);
            end
        end
    end

    initial begin
        fork
            begin : streamA
                bit ill;
                logic [4:0] badEnc [4] = '{5'b00000, 5'b01101, 5'b11011, 5'b10011};
                logic [4:0] enc;
                doReset(0, T_RESET, 1'b0, 1'b0);
                runInstr(0, 3'b110, 2'b10, 0, T_NONE, 0, ill);
                runInstr(0, 3'b101, 2'b00, 0, T_NONE, 0, ill);
                runInstr(0, 3'b101, 2'b01, 0, T_NONE, 0, ill);
                randomLegal(0, 30);
                runInstr(0, 3'b111, 2'($urandom), 100, T_NONE, 0, ill);
                doReset(0, T_HALT, ill, 1'b1);
                runInstr(0, 3'b000, 2'b00, 100, T_NONE, 0, ill);
                doReset(0, T_HALT, ill, 1'b1);
                for (int i = 0; i < 4; i++) begin
                    enc = badEnc[i];
                    runInstr(0, enc[4:2], enc[1:0], 3, T_NONE, 0, ill);
                    doReset(0, T_HALT, ill, 1'b1);
                end
                runInstr(0, 3'b110, 2'b10, 0, T_NONE, 0, ill);
            end
            begin : streamB
                bit ill;
                doReset(1, T_RESET, 1'b0, 1'b0);
                runInstr(1, 3'b011, 2'b00, 0, T_NONE, 0, ill);
                runInstr(1, 3'b100, 2'b00, 0, T_NONE, 0, ill);
                randomLegal(1, 15);
                runInstr(1, 3'b110, 2'b10, 0, T_FETCH, 0, ill);
                runInstr(1, 3'b011, 2'b00, 0, T_NONE, 0, ill);
                runInstr(1, 3'b100, 2'b00, 0, T_MEM_WR, 0, ill);
                runInstr(1, 3'b101, 2'b01, 0, T_NONE, 0, ill);
            end
            begin : streamC
                bit ill;
                doReset(2, T_RESET, 1'b0, 1'b0);
                runInstr(2, 3'b110, 2'b10, 0, T_NONE, 6, ill);
                randomLegal(2, 20);
                runInstr(2, 3'b100, 2'b00, 0, T_MEM_WR, 0, ill);
                runInstr(2, 3'b011, 2'b00, 0, T_NONE, 0, ill);
                runInstr(2, 3'b111, 2'b11, 5, T_NONE, 0, ill);
            end
        join
        repeat (2) @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            checkCount++;
            if (expQ[k].size() != 0) begin
                errorCount++;
                $display("[TB] FAIL dut%0d drain leftover=%0d expected=0", k, expQ[k].size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
